video_scale_wr_arb: RTL and testbench

Round-robin scheduler that shares a single burst-write memory port between four `video_scale_960_540` channels, one per quadrant of a 1920×1080 split-screen frame buffer. Each channel's scaled stream lands in a show-ahead line FIFO upstream. This block decides which FIFO drains next and computes the quadrant-mapped byte address of every burst. It issues one command plus exactly `BURST_LEN` data beats per grant to the frame-buffer write controller.

---
 rtl/video_arb_pkg.sv | 34 +++
 rtl/video_scale_wr_arb_rr_arb4.sv | 23 ++
 rtl/video_scale_wr_arb.sv | 188 ++++++++++++++++++
 tb/tb_video_scale_wr_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_arb_pkg.sv
// Shared types and address helpers for the quadrant write scheduler.
package video_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} arb_state_e;

  // Byte stride of one full-width frame-buffer line (two quadrants side by side).
  function automatic logic [63:0] line_stride(input int out_w);
    return 64'(2 * out_w * 4);
  endfunction

  // Byte offset of a channel's quadrant origin: qx = ch[0], qy = ch[1].
  function automatic logic [63:0] quad_offset(input logic [1:0] ch, input int out_w,
                                              input int out_h);
    logic [63:0] off;
    off = ch[0] ? 64'(out_w * 4) : 64'd0;
    if (ch[1]) off = off + 64'(out_h) * line_stride(out_w);
    return off;
  endfunction

  // Size of one complete 4-quadrant frame buffer in bytes.
  function automatic logic [63:0] frame_bytes(input int out_w, input int out_h);
    return 64'(4 * 4 * out_w * out_h);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/video_scale_wr_arb_rr_arb4.sv
// Combinational 4-way round-robin pick: highest priority at ptr, then upward mod 4.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] winner,
  output logic       req_any
);

  logic [1:0] idx;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    winner = '0;
    idx    = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) winner = 4'b0001 << idx;
    end
    req_any = |req;
  end

endmodule

// File: rtl/video_scale_wr_arb.sv
// Round-robin burst-write scheduler: four quadrant line FIFOs share one frame-buffer write port.
// Define VIDEO_ARB_PINGPONG_EN for per-channel double buffering exposed on fb_sel.
module video_scale_wr_arb
  import video_arb_pkg::*;
#(
  parameter int OUT_W     = 960,
  parameter int OUT_H     = 540,
  parameter int BURST_LEN = 64,
  parameter int ADDR_W    = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        vs_in,
  input  logic [3:0]        req,
  output logic [3:0]        fifo_rd_en,
  input  logic [127:0]      fifo_rd_data,
  output logic [3:0]        grant,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic [31:0]       wr_data,
  output logic              wr_data_last
`ifdef VIDEO_ARB_PINGPONG_EN
  ,
  output logic [3:0]        fb_sel
`endif
);

  localparam int XW_W = $clog2(OUT_W + 1);
  localparam int LN_W = $clog2(OUT_H + 1);
  localparam logic [XW_W-1:0] XW_LAST = XW_W'(OUT_W - BURST_LEN);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(OUT_H - 1);
  localparam logic [7:0]      LEN_M1  = 8'(BURST_LEN - 1);

  arb_state_e      state, state_nxt;
  logic [1:0]      ptr, widx;
  logic [3:0]      winner;
  logic            req_any;
  logic [XW_W-1:0] xw [4];
  logic [LN_W-1:0] ln [4];
  logic [XW_W-1:0] xw_eff;
  logic [LN_W-1:0] ln_eff;
  logic [3:0]      pend;
  logic [7:0]      beat;
  logic [63:0]     addr_full;
  logic            last_beat;

  rr_arb4 u_rr (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .req_any (req_any)
  );

  assign widx      = onehot_idx(winner);
  assign last_beat = (beat == LEN_M1);

`ifdef VIDEO_ARB_PINGPONG_EN
  logic [3:0] fb, fb_pend;
  assign fb_sel = fb;
`endif

  // A frame start arriving in the grant cycle already counts for the burst being issued.
  always_comb begin
    xw_eff    = vs_in[widx] ? '0 : xw[widx];
    ln_eff    = vs_in[widx] ? '0 : ln[widx];
    addr_full = 64'(BASE_ADDR) + quad_offset(widx, OUT_W, OUT_H)
              + 64'(ln_eff) * line_stride(OUT_W) + 64'(xw_eff) * 64'd4;
`ifdef VIDEO_ARB_PINGPONG_EN
    if (fb[widx] ^ vs_in[widx]) addr_full = addr_full + frame_bytes(OUT_W, OUT_H);
`endif
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    wr_cmd_valid  = 1'b0;
    wr_data_valid = 1'b0;
    wr_data_last  = 1'b0;
    fifo_rd_en    = '0;
    wr_data       = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) wr_data = fifo_rd_data[32*i +: 32];
    end
    unique case (state)
      IDLE: if (req_any) state_nxt = CMD;
      CMD: begin
        wr_cmd_valid = 1'b1;
        if (wr_cmd_ready) state_nxt = DATA;
      end
      DATA: begin
        wr_data_valid = 1'b1;
        wr_data_last  = last_beat;
        fifo_rd_en    = grant & {4{wr_data_ready}};
        if (wr_data_ready && last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      ptr         <= '0;
      beat        <= '0;
      wr_cmd_addr <= '0;
      wr_cmd_len  <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_any) begin
          grant       <= winner;
          wr_cmd_addr <= addr_full[ADDR_W-1:0];
          wr_cmd_len  <= LEN_M1;
          beat        <= '0;
        end
        DATA: if (wr_data_ready) beat <= beat + 8'd1;
        DONE: begin
          grant <= '0;
          ptr   <= onehot_idx(grant) + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the xw/ln arrays are a handful of flops, not RAM, so they are reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        xw[i] <= '0;
        ln[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state == DONE && grant[i]) begin
          pend[i] <= 1'b0;
          if (pend[i] || vs_in[i]) begin
            xw[i] <= '0;
            ln[i] <= '0;
          end else if (xw[i] == XW_LAST) begin
            xw[i] <= '0;
            ln[i] <= (ln[i] == LN_LAST) ? '0 : ln[i] + LN_W'(1);
          end else begin
            xw[i] <= xw[i] + XW_W'(BURST_LEN);
          end
        end else if (vs_in[i]) begin
          if (grant[i]) pend[i] <= 1'b1;
          else begin
            xw[i] <= '0;
            ln[i] <= '0;
          end
        end
      end
    end
  end

`ifdef VIDEO_ARB_PINGPONG_EN
  // fb_pend holds the parity of toggles seen during the channel's own burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb      <= '0;
      fb_pend <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state == DONE && grant[i]) begin
          fb[i]      <= fb[i] ^ fb_pend[i] ^ vs_in[i];
          fb_pend[i] <= 1'b0;
        end else if (vs_in[i]) begin
          if (grant[i]) fb_pend[i] <= ~fb_pend[i];
          else          fb[i]      <= ~fb[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_scale_wr_arb.sv
// Directed bench for video_scale_wr_arb with a burst-count scoreboard model checked every cycle.
module tb_video_scale_wr_arb;

  localparam int OUT_W     = 960;
  localparam int OUT_H     = 540;
  localparam int BURST_LEN = 64;
  localparam int ADDR_W    = 28;
  localparam int BPL       = OUT_W / BURST_LEN;
`ifdef VIDEO_ARB_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        vs_in = '0;
  logic [3:0]        req = '0;
  logic [3:0]        fifo_rd_en;
  logic [127:0]      fifo_rd_data;
  logic [3:0]        grant;
  logic              wr_cmd_valid;
  logic              wr_cmd_ready = 1'b1;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [7:0]        wr_cmd_len;
  logic              wr_data_valid;
  logic              wr_data_ready = 1'b1;
  logic [31:0]       wr_data;
  logic              wr_data_last;
`ifdef VIDEO_ARB_PINGPONG_EN
  logic [3:0]        fb_sel;
`endif

  video_scale_wr_arb #(
    .OUT_W(OUT_W), .OUT_H(OUT_H), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .BASE_ADDR('0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vs_in         (vs_in),
    .req           (req),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .grant         (grant),
    .wr_cmd_valid  (wr_cmd_valid),
    .wr_cmd_ready  (wr_cmd_ready),
    .wr_cmd_addr   (wr_cmd_addr),
    .wr_cmd_len    (wr_cmd_len),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .wr_data_last  (wr_data_last)
`ifdef VIDEO_ARB_PINGPONG_EN
    ,
    .fb_sel        (fb_sel)
`endif
  );

  always #5 clk = ~clk;

  // Upstream show-ahead FIFOs: head word is {channel, pop count}.
  logic [23:0] pops [4] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (fifo_rd_en[i]) pops[i] <= pops[i] + 24'd1;
  end
  always_comb begin
    fifo_rd_data = '0;
    for (int i = 0; i < 4; i++) fifo_rd_data[32*i +: 32] = {8'(i), pops[i]};
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr, m_ch, sb_c, sb_beat, sb_rden, sb_last, cyc;
  bit          m_in_burst, m_pend, m_fbp;
  int          m_n [4];
  bit          m_fb [4];
  logic [23:0] m_word [4] = '{default: '0};
  logic [ADDR_W-1:0] addr_q [$];
  int          ch_q [$];
  int          hs_q [$];
  int          rden_q [$];
  int          last_q [$];

  function automatic int rr(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // n = bursts this channel has written since its frame start.
  function automatic logic [ADDR_W-1:0] model_addr(input int ch, input int n, input bit fbv);
    longint unsigned line, x, a;
    line = longint'((n / BPL) % OUT_H);
    x    = longint'((n % BPL) * BURST_LEN);
    a = 4 * ((longint'(ch / 2) * OUT_H + line) * 2 * OUT_W + longint'(ch % 2) * OUT_W + x);
    if (PP && fbv) a = a + longint'(16 * OUT_W * OUT_H);
    return a[ADDR_W-1:0];
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_ptr = 0; m_in_burst = 0; m_pend = 0; m_fbp = 0; sb_beat = 0;
      for (int i = 0; i < 4; i++) begin m_n[i] = 0; m_fb[i] = 0; end
    end else begin
      check("data_valid_window", wr_data_valid, m_in_burst);
      check("fifo_rd_en", fifo_rd_en, (m_in_burst && wr_data_ready) ? (4'b0001 << m_ch) : 4'b0000);
      check("wr_data_last", wr_data_last, m_in_burst && sb_beat == BURST_LEN - 1);
      for (int i = 0; i < 4; i++) if (vs_in[i]) begin
        if (m_in_burst && m_ch == i) begin m_pend = 1; m_fbp = ~m_fbp; end
        else begin m_n[i] = 0; m_fb[i] = ~m_fb[i]; end
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        sb_c = rr(req, m_ptr);
        if (sb_c < 0) check("cmd_without_req", {28'd0, req}, 1);
        else begin
          check("grant", grant, 4'b0001 << sb_c);
          check("cmd_addr", wr_cmd_addr, model_addr(sb_c, m_n[sb_c], m_fb[sb_c]));
          check("cmd_len", wr_cmd_len, BURST_LEN - 1);
          addr_q.push_back(wr_cmd_addr);
          ch_q.push_back(sb_c);
          hs_q.push_back(cyc);
          m_ch = sb_c; m_in_burst = 1; sb_beat = 0; sb_rden = 0; sb_last = 0;
        end
      end else if (wr_data_valid && m_in_burst) begin
        check("wr_data", wr_data, {8'(m_ch), m_word[m_ch]});
        if (wr_data_last) sb_last++;
        if (wr_data_ready) begin
          if (fifo_rd_en[m_ch]) sb_rden++;
          m_word[m_ch]++;
          sb_beat++;
          if (sb_beat == BURST_LEN) begin
            m_in_burst = 0;
            m_ptr = (m_ch + 1) % 4;
            m_n[m_ch] = m_pend ? 0 : m_n[m_ch] + 1;
            m_fb[m_ch] = m_fb[m_ch] ^ m_fbp;
            m_pend = 0; m_fbp = 0;
            rden_q.push_back(sb_rden);
            last_q.push_back(sb_last);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req = '0; vs_in = '0; wr_cmd_ready = 1; wr_data_ready = 1;
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_cmd_valid", wr_cmd_valid, 0);
    check("rst_cmd_addr", wr_cmd_addr, 0);
    check("rst_cmd_len", wr_cmd_len, 0);
    check("rst_data_valid", wr_data_valid, 0);
    check("rst_wr_data", wr_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_bursts(input int n);
    int target = last_q.size() + n;
    int t = 0;
    while (last_q.size() < target && t < 200 * n) begin @(posedge clk); #1; t++; end
    if (last_q.size() < target) check("burst_timeout", last_q.size(), target);
  endtask

  task automatic wait_beat(input int b);
    int t = 0;
    while (!(m_in_burst && sb_beat == b) && t < 400) begin @(posedge clk); #1; t++; end
    if (!(m_in_burst && sb_beat == b)) check("beat_timeout", sb_beat, b);
  endtask

  logic [ADDR_W-1:0] quad_exp [3] = '{28'hF00, 28'h3F4800, 28'h3F5700};
  int grant_exp [5] = '{0, 1, 2, 3, 0};
  int ba, bl;

  initial begin
    // Single burst from channel 0.
    do_reset();
    ba = addr_q.size(); bl = last_q.size();
    req = 4'b0001;
    wait_bursts(1);
    req = '0;
    repeat (10) @(posedge clk);
    #1;
    check("t1_addr", addr_q[ba], 28'h0);
    check("t1_rden_count", rden_q[bl], 64);
    check("t1_last_count", last_q[bl], 1);
    check("t1_no_more_bursts", addr_q.size(), ba + 1);

    // Quadrant origins of channels 1..3; channel 1 also sees a stalled command handshake.
    for (int ch = 1; ch < 4; ch++) begin
      do_reset();
      ba = addr_q.size();
      req = 4'b0001 << ch;
      if (ch == 1) begin
        wr_cmd_ready = 0;
        repeat (4) @(posedge clk);
        #1;
        check("t2_cmd_valid_held", wr_cmd_valid, 1);
        wr_cmd_ready = 1;
      end
      wait_bursts(1);
      req = '0;
      check("t2_quad_addr", addr_q[ba], quad_exp[ch-1]);
    end

    // Sixteen bursts on channel 0 cross into line 1.
    do_reset();
    ba = addr_q.size();
    req = 4'b0001;
    wait_bursts(16);
    req = '0;
    check("t3_addr_burst15", addr_q[ba+14], 28'hE00);
    check("t3_addr_line1", addr_q[ba+15], 28'h1E00);

    // All channels requesting: rotation and best-case spacing.
    do_reset();
    ba = addr_q.size();
    req = 4'b1111;
    wait_bursts(5);
    req = '0;
    for (int k = 0; k < 5; k++) check("t4_grant_order", ch_q[ba+k], grant_exp[k]);
    for (int k = 0; k < 4; k++) check("t4_burst_cycles", hs_q[ba+k+1] - hs_q[ba+k], BURST_LEN + 3);

    // Data-side stall of 5 cycles at beat 10.
    do_reset();
    bl = last_q.size();
    req = 4'b0001;
    wait_beat(10);
    wr_data_ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t5_valid_in_stall", wr_data_valid, 1);
    end
    wr_data_ready = 1;
    wait_bursts(1);
    req = '0;
    check("t5_rden_count", rden_q[bl], 64);
    check("t5_last_count", last_q[bl], 1);

    // Frame start during channel 0's third burst.
    do_reset();
    ba = addr_q.size();
    req = 4'b0001;
    wait_bursts(2);
    wait_beat(10);
    vs_in = 4'b0001;
    @(posedge clk); #1;
    vs_in = '0;
    wait_bursts(2);
    req = '0;
    check("t6_third_addr", addr_q[ba+2], 28'h200);
    check("t6_after_vs_addr", addr_q[ba+3], PP ? 28'h7E9000 : 28'h0);
`ifdef VIDEO_ARB_PINGPONG_EN
    check("t6_fb_sel", fb_sel, 4'b0001);
`endif

    // Frame start while channel 0 is idle clears its position.
    do_reset();
    ba = addr_q.size();
    req = 4'b0001;
    wait_bursts(2);
    req = '0;
    repeat (5) @(posedge clk);
    #1 vs_in = 4'b0001;
    @(posedge clk); #1;
    vs_in = '0;
    req = 4'b0001;
    wait_bursts(1);
    req = '0;
    check("t7_idle_vs_addr", addr_q[ba+2], PP ? 28'h7E9000 : 28'h0);

    // Reset mid-burst aborts without a last beat and restarts from the origin.
    do_reset();
    req = 4'b0001;
    wait_beat(20);
    bl = last_q.size();
    rst = 1;
    @(negedge clk);
    check("t8_rst_valid", wr_data_valid, 0);
    check("t8_rst_last", wr_data_last, 0);
    check("t8_rst_rd_en", fifo_rd_en, 0);
    check("t8_rst_grant", grant, 0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("t8_no_completion", last_q.size(), bl);
    ba = addr_q.size();
    req = 4'b0001;
    wait_bursts(1);
    req = '0;
    check("t8_restart_addr", addr_q[ba], 28'h0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
